// File: rtl/fmt_stream_sched.sv
// +--------------------------------------------------------------------------+
// | fmt_stream_sched: round-robin integer formatter (%b/%o/%d/%h, %0), one   |
// | ASCII char per cycle. Option: FMT_STREAM_UPPER_HEX_EN adds req_upper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fmt_stream_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_value,
  input  logic [2*NREQ-1:0]    req_radix,
  input  logic [NREQ-1:0]      req_nopad,
`ifdef FMT_STREAM_UPPER_HEX_EN
  input  logic [NREQ-1:0]      req_upper,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 out_last,
  output logic [IDW-1:0]       out_src,
  output logic                 busy
);

  localparam logic [1:0] c_rad_bin = 2'd0;
  localparam logic [1:0] c_rad_oct = 2'd1;
  localparam logic [1:0] c_rad_dec = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_src;
  logic [31:0]     r_val;
  logic [39:0]     r_bcd;
  logic [1:0]      r_radix;
  logic            r_nopad;
  logic [4:0]      r_cnt;
  logic [4:0]      r_pos;
  logic            r_lead;
  logic            w_upper;

  // ---------------- arbitration ----------------
  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_ptr_nxt;
  int              w_idx;
  logic [31:0]     w_sel_value;
  logic [1:0]      w_sel_radix;
  logic            w_grant;

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(w_idx);
      end
    end
  end

  assign w_ptr_nxt   = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + IDW'(1);
  assign w_sel_value = req_value[32*int'(w_gnt) +: 32];
  assign w_sel_radix = req_radix[2*int'(w_gnt) +: 2];
  assign w_grant     = (r_state == S_IDLE) && w_found;

  // ---------------- double-dabble adjust ----------------
  logic [39:0] w_bcd_adj;

  for (genvar d = 0; d < 10; d++) begin : g_dd
    assign w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                           : r_bcd[4*d +: 4];
  end

  // ---------------- digit selection ----------------
  logic [39:0] w_src40;
  logic [5:0]  w_shamt;
  logic [3:0]  w_mask;
  logic [3:0]  w_dig;
  logic        w_lastpos;
  logic        w_lead_zero;
  logic        w_skip;
  logic        w_adv;
  logic [7:0]  w_char;

  assign w_src40 = (r_radix == c_rad_dec) ? r_bcd : {8'h00, r_val};

  always_comb begin
    w_shamt = 6'({r_pos, 2'b00});
    w_mask  = 4'hf;
    if (r_radix == c_rad_bin) begin
      w_shamt = {1'b0, r_pos};
      w_mask  = 4'h1;
    end else if (r_radix == c_rad_oct) begin
      w_shamt = 6'(r_pos * 5'd3);
      w_mask  = 4'h7;
    end
  end

  assign w_dig       = w_src40[w_shamt +: 4] & w_mask;
  assign w_lastpos   = (r_pos == 5'd0);
  assign w_lead_zero = r_lead && (w_dig == 4'd0) && !w_lastpos;
  assign w_skip      = (r_state == S_EMIT) && w_lead_zero && r_nopad;
  assign w_adv       = w_skip || (out_valid && out_ready);

  // 'A'-10 = 0x37, 'a'-10 = 0x57
  always_comb begin
    if (w_lead_zero)
      w_char = (r_radix == c_rad_dec) ? 8'h20 : 8'h30;
    else if (w_dig < 4'd10)
      w_char = 8'h30 + {4'h0, w_dig};
    else
      w_char = (w_upper ? 8'h37 : 8'h57) + {4'h0, w_dig};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready   = NREQ'(1) << w_gnt;
          w_state_nxt = (w_sel_radix == c_rad_dec) ? S_CONV : S_EMIT;
        end
      end
      S_CONV: begin
        busy = 1'b1;
        if (r_cnt == 5'd31) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = !(w_lead_zero && r_nopad);
        if (w_adv && w_lastpos) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_char = out_valid ? w_char : 8'h00;
  assign out_last = out_valid && w_lastpos;
  assign out_src  = r_src;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_src   <= '0;
      r_val   <= '0;
      r_bcd   <= '0;
      r_radix <= '0;
      r_nopad <= 1'b0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_lead  <= 1'b0;
    end else if (w_grant) begin
      r_ptr   <= w_ptr_nxt;
      r_src   <= w_gnt;
      r_val   <= w_sel_value;
      r_bcd   <= '0;
      r_radix <= w_sel_radix;
      r_nopad <= req_nopad[w_gnt];
      r_cnt   <= '0;
      r_lead  <= 1'b1;
      case (w_sel_radix)
        c_rad_bin: r_pos <= 5'd31;
        c_rad_oct: r_pos <= 5'd10;
        c_rad_dec: r_pos <= 5'd9;
        default:   r_pos <= 5'd7;
      endcase
    end else if (r_state == S_CONV) begin
      r_bcd <= 40'({w_bcd_adj, r_val[31]});
      r_val <= {r_val[30:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
    end else if (r_state == S_EMIT && w_adv) begin
      r_pos  <= r_pos - 5'd1;
      r_lead <= r_lead && (w_dig == 4'd0);
    end
  end

`ifdef FMT_STREAM_UPPER_HEX_EN
  logic r_upper;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_upper <= 1'b0;
    else if (w_grant) r_upper <= req_upper[w_gnt];
  end
  assign w_upper = r_upper;
`else
  assign w_upper = 1'b0;
`endif

endmodule

`default_nettype wire
